// File: rtl/arbiter_demux.sv
// ============================================================================
//  Module   : arbiter_demux
//  Brief    : Receive side of the arbiter slot stream. Acquires frame
//             alignment, rebuilds the SOP/POS pair once per frame and counts
//             sync errors while locked.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_demux #(
    parameter int SLOTS       = 4,
    parameter int DW          = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int UNLOCK_ERRS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_d,
    input  logic          in_sync,
    output logic [DW-1:0] out_sop,
    output logic [DW-1:0] out_pos,
    output logic          out_valid,
    output logic          locked,
    output logic [7:0]    sync_err_cnt
);

    localparam int c_SW = $clog2(SLOTS);
    localparam int c_GW = $clog2(LOCK_FRAMES + 1);
    localparam int c_EW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [c_SW-1:0] c_LAST_SLOT = c_SW'(SLOTS - 1);
    localparam logic [c_SW-1:0] c_SLOT1     = c_SW'(1);
    localparam logic [c_GW-1:0] c_LOCK      = c_GW'(LOCK_FRAMES);
    localparam logic [c_EW-1:0] c_UNLOCK    = c_EW'(UNLOCK_ERRS);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_d;
    logic            r_sync;
    logic [c_SW-1:0] r_slot;
    logic [c_GW-1:0] r_good;
    logic [c_EW-1:0] r_err_run;
    logic [DW-1:0]   r_sop_hold;
    logic            r_frame_ok;
    logic [DW-1:0]   r_sop;
    logic [DW-1:0]   r_pos;
    logic            r_valid;
    logic            r_locked;
    logic [7:0]      r_err_cnt;

    logic [c_SW-1:0] w_slot_next;
    logic [c_GW-1:0] w_good_inc;
    logic [c_EW-1:0] w_err_run_inc;
    logic [7:0]      w_err_cnt_inc;
    logic            w_slot0;
    logic            w_slot1;
    logic            w_is_err;
    logic            w_unlock;

    assign w_slot_next   = (r_slot == c_LAST_SLOT) ? '0 : r_slot + c_SW'(1);
    assign w_good_inc    = r_good + c_GW'(1);
    assign w_err_run_inc = r_err_run + c_EW'(1);
    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
    assign w_slot0       = (r_slot == '0);
    assign w_slot1       = (r_slot == c_SLOT1);

    // While locked, a missing sync at slot 0 and a spurious sync elsewhere are both errors
    assign w_is_err = (w_slot0 && !r_sync) || (!w_slot0 && r_sync);
    assign w_unlock = w_is_err && (w_err_run_inc == c_UNLOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HUNT;
            r_d        <= '0;
            r_sync     <= 1'b0;
            r_slot     <= '0;
            r_good     <= '0;
            r_err_run  <= '0;
            r_sop_hold <= '0;
            r_frame_ok <= 1'b0;
            r_sop      <= '0;
            r_pos      <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_d     <= in_d;
            r_sync  <= in_sync;
            r_valid <= 1'b0;

            case (r_state)
                S_HUNT: begin
                    if (r_sync) begin
                        r_sop_hold <= r_d;
                        r_slot     <= c_SLOT1;
                        r_good     <= c_GW'(1);
                        if (LOCK_FRAMES <= 1) begin
                            r_state    <= S_LOCKED;
                            r_locked   <= 1'b1;
                            r_frame_ok <= 1'b1;
                            r_err_run  <= '0;
                        end else begin
                            r_state <= S_CONFIRM;
                        end
                    end
                end

                S_CONFIRM: begin
                    r_slot <= w_slot_next;
                    if (r_sync && w_slot0) begin
                        r_sop_hold <= r_d;
                        r_good     <= w_good_inc;
                        // The locking frame counts as good, so its pair is emitted
                        if (w_good_inc == c_LOCK) begin
                            r_state    <= S_LOCKED;
                            r_locked   <= 1'b1;
                            r_frame_ok <= 1'b1;
                            r_err_run  <= '0;
                        end
                    end else if (r_sync) begin
                        r_slot     <= c_SLOT1;
                        r_good     <= c_GW'(1);
                        r_sop_hold <= r_d;
                    end else if (w_slot0) begin
                        r_state <= S_HUNT;
                    end
                end

                S_LOCKED: begin
                    r_slot <= w_slot_next;
                    if (w_slot0 && r_sync) begin
                        r_sop_hold <= r_d;
                        r_err_run  <= '0;
                        r_frame_ok <= 1'b1;
                    end else if (w_slot0) begin
                        r_frame_ok <= 1'b0;
                    end

                    if (w_is_err) begin
                        r_err_cnt <= w_err_cnt_inc;
                        if (w_unlock) begin
                            r_state    <= S_HUNT;
                            r_locked   <= 1'b0;
                            r_err_run  <= '0;
                            r_frame_ok <= 1'b0;
                        end else begin
                            r_err_run <= w_err_run_inc;
                        end
                    end

                    if (w_slot1 && r_frame_ok && !w_unlock) begin
                        r_pos   <= r_d;
                        r_sop   <= r_sop_hold;
                        r_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign out_sop      = r_sop;
    assign out_pos      = r_pos;
    assign out_valid    = r_valid;
    assign locked       = r_locked;
    assign sync_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_demux.sv
// ============================================================================
//  Module   : tb_arbiter_demux
//  Brief    : Directed self-checking bench for arbiter_demux.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_d;
    logic       in_sync;
    logic [7:0] out_sop;
    logic [7:0] out_pos;
    logic       out_valid;
    logic       locked;
    logic [7:0] sync_err_cnt;

    int checks = 0;
    int fails  = 0;
    int vcnt   = 0;
    int bad    = 0;
    logic [7:0] last_sop = 8'h00;
    logic [7:0] last_pos = 8'h00;

    arbiter_demux #(
        .SLOTS       (4),
        .DW          (8),
        .LOCK_FRAMES (2),
        .UNLOCK_ERRS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_d         (in_d),
        .in_sync      (in_sync),
        .out_sop      (out_sop),
        .out_pos      (out_pos),
        .out_valid    (out_valid),
        .locked       (locked),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counter and last emitted pair, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            vcnt++;
            last_sop = out_sop;
            last_pos = out_pos;
            if (locked !== 1'b1) bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic s);
        in_d    = d;
        in_sync = s;
        @(posedge clk);
        #1;
    endtask

    // One frame: SOP, POS, two nonzero idle words; spur selects a slot carrying a stray sync
    task automatic frame(input logic [7:0] sop, input logic [7:0] pos, input logic s0, input int spur);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            case (i)
                0:       d = sop;
                1:       d = pos;
                2:       d = 8'hFF;
                default: d = 8'h5E;
            endcase
            step(d, (i == 0) ? s0 : (spur == i));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_d    = 8'h00;
        in_sync = 1'b0;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("rst_valid",  32'(out_valid),    0);
        chk("rst_locked", 32'(locked),       0);
        chk("rst_errcnt", 32'(sync_err_cnt), 0);
        chk("rst_sop",    32'(out_sop),      0);
        chk("rst_pos",    32'(out_pos),      0);

        rst_n = 1'b1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Clean acquisition
        frame(8'hA5, 8'h3C, 1'b1, 0);
        chk("confirm_locked", 32'(locked), 0);
        chk("confirm_vcnt",   32'(vcnt),   0);
        step(8'hA5, 1'b1);
        chk("lock_early", 32'(locked), 0);
        step(8'h3C, 1'b0);
        chk("lock_rise",  32'(locked),    1);
        chk("lock_novld", 32'(out_valid), 0);
        step(8'hFF, 1'b0);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_sop",   32'(out_sop),   32'hA5);
        chk("first_pos",   32'(out_pos),   32'h3C);
        step(8'h5E, 1'b0);
        chk("valid_pulse", 32'(out_valid), 0);
        frame(8'hA5, 8'h3C, 1'b1, 0);
        frame(8'hA5, 8'h3C, 1'b1, 0);
        chk("clean_vcnt",   32'(vcnt),         3);
        chk("clean_errcnt", 32'(sync_err_cnt), 0);

        // Single dropped sync, then err_run must have cleared
        frame(8'h11, 8'h22, 1'b0, 0);
        chk("drop1_vcnt",   32'(vcnt),         3);
        chk("drop1_locked", 32'(locked),       1);
        chk("drop1_errcnt", 32'(sync_err_cnt), 1);
        frame(8'h66, 8'h77, 1'b1, 0);
        chk("after_drop_vcnt", 32'(vcnt),     4);
        chk("after_drop_sop",  32'(last_sop), 32'h66);
        chk("after_drop_pos",  32'(last_pos), 32'h77);
        frame(8'h11, 8'h22, 1'b0, 0);
        frame(8'h11, 8'h22, 1'b0, 0);
        chk("errrun_cleared_locked", 32'(locked),       1);
        chk("drop2_errcnt",          32'(sync_err_cnt), 3);
        frame(8'h88, 8'h99, 1'b1, 0);
        chk("recover_vcnt", 32'(vcnt),     5);
        chk("recover_sop",  32'(last_sop), 32'h88);
        chk("recover_pos",  32'(last_pos), 32'h99);

        // Three consecutive drops lose lock
        frame(8'h11, 8'h22, 1'b0, 0);
        frame(8'h11, 8'h22, 1'b0, 0);
        chk("two_drops_locked", 32'(locked), 1);
        frame(8'h11, 8'h22, 1'b0, 0);
        chk("unlock_locked", 32'(locked),       0);
        chk("unlock_errcnt", 32'(sync_err_cnt), 6);
        frame(8'hA5, 8'h3C, 1'b1, 0);
        chk("relock1_locked", 32'(locked), 0);
        chk("relock1_vcnt",   32'(vcnt),   5);
        frame(8'hB1, 8'hB2, 1'b1, 0);
        chk("relock2_locked", 32'(locked),   1);
        chk("relock2_vcnt",   32'(vcnt),     6);
        chk("relock2_sop",    32'(last_sop), 32'hB1);
        chk("relock2_pos",    32'(last_pos), 32'hB2);

        // Spurious sync at slot 2
        frame(8'hC1, 8'hC2, 1'b1, 2);
        chk("spur_errcnt", 32'(sync_err_cnt), 7);
        chk("spur_locked", 32'(locked),       1);
        chk("spur_vcnt",   32'(vcnt),         7);
        frame(8'h5A, 8'hC3, 1'b1, 0);
        chk("spur_next_vcnt", 32'(vcnt),     8);
        chk("spur_next_sop",  32'(last_sop), 32'h5A);
        chk("spur_next_pos",  32'(last_pos), 32'hC3);

        // Drop lock, then realign in CONFIRM on a sync at slot 3
        frame(8'h11, 8'h22, 1'b0, 0);
        frame(8'h11, 8'h22, 1'b0, 0);
        frame(8'h11, 8'h22, 1'b0, 0);
        chk("realign_pre_locked", 32'(locked),       0);
        chk("realign_pre_errcnt", 32'(sync_err_cnt), 10);
        step(8'hD1, 1'b1);
        step(8'hD2, 1'b0);
        step(8'h00, 1'b0);
        step(8'hE1, 1'b1);
        step(8'hE2, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'hF1, 1'b1);
        chk("realign_not_yet", 32'(locked), 0);
        step(8'hF2, 1'b0);
        chk("realign_locked", 32'(locked), 1);
        chk("realign_novld",  32'(vcnt),   8);
        step(8'h00, 1'b0);
        chk("realign_valid", 32'(out_valid), 1);
        chk("realign_sop",   32'(out_sop),   32'hF1);
        chk("realign_pos",   32'(out_pos),   32'hF2);
        step(8'h00, 1'b0);

        // Saturate the error counter while holding lock
        for (int i = 0; i < 300; i++) begin
            frame(8'h33, 8'h44, 1'b0, 0);
            frame(8'h55, 8'h66, 1'b1, 0);
            if (i == 99) chk("errcnt_mid", 32'(sync_err_cnt), 110);
        end
        chk("sat_errcnt", 32'(sync_err_cnt), 255);
        chk("sat_locked", 32'(locked),       1);
        chk("sat_vcnt",   32'(vcnt),         309);
        chk("sat_sop",    32'(last_sop),     32'h55);
        chk("sat_pos",    32'(last_pos),     32'h66);
        chk("never_unlocked_valid", 32'(bad), 0);

        // Asynchronous reset mid-frame
        step(8'h77, 1'b1);
        step(8'h88, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("arst_sop",    32'(out_sop),      0);
        chk("arst_pos",    32'(out_pos),      0);
        chk("arst_valid",  32'(out_valid),    0);
        chk("arst_locked", 32'(locked),       0);
        chk("arst_errcnt", 32'(sync_err_cnt), 0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        rst_n = 1'b1;
        step(8'h00, 1'b0);
        chk("post_rst_locked", 32'(locked), 0);
        frame(8'h12, 8'h34, 1'b1, 0);
        chk("post_rst_confirm", 32'(locked), 0);
        chk("post_rst_vcnt",    32'(vcnt),   309);
        frame(8'h56, 8'h78, 1'b1, 0);
        chk("post_rst_relock", 32'(locked),       1);
        chk("post_rst_vcnt2",  32'(vcnt),         310);
        chk("post_rst_errcnt", 32'(sync_err_cnt), 0);
        chk("post_rst_sop",    32'(last_sop),     32'h56);
        chk("post_rst_pos",    32'(last_pos),     32'h78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
